// File: rtl/sweep_ctrl.sv
// Frequency-sweep sequencer: steps the generator's set_count from a start value toward a stop
// value, advancing after a programmed number of address-counter periods.
module sweep_ctrl #(
   parameter int CNT_W     = 32,
   parameter int ADDR_W    = 10,
   parameter int DWELL_W   = 16,
   parameter int MIN_COUNT = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [CNT_W-1:0]   cfg_start_cnt,
   input  logic [CNT_W-1:0]   cfg_stop_cnt,
   input  logic [CNT_W-1:0]   cfg_step,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic [1:0]         cfg_mode,
   input  logic [3:0]         cfg_sig_type,
   input  logic [ADDR_W-1:0]  gen_addr,
   output logic [CNT_W-1:0]   set_count,
   output logic [3:0]         sig_type,
   output logic               gen_rst_n,
   output logic               busy,
   output logic               done
);

   localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_COUNT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   base_cnt;
   logic [CNT_W-1:0]   tgt_cnt;
   logic [CNT_W-1:0]   step_cnt;
   logic [DWELL_W-1:0] dwell_cfg;
   logic [DWELL_W-1:0] dwell_cnt;
   logic [1:0]         mode;
   logic [3:0]         sig_cfg;
   logic               dir_up;
   logic [ADDR_W-1:0]  prev_addr;

   logic               wrap;
   logic [DWELL_W-1:0] dwell_eff;
   logic [DWELL_W:0]   dwell_next;
   logic               step_done;
   logic               at_end;

   function automatic logic [CNT_W-1:0] floor_min(input logic [CNT_W-1:0] v);
      return (v < MIN_C) ? MIN_C : v;
   endfunction

   // Move cur by stp toward tgt, clamping to tgt on overshoot or wrap-around of CNT_W.
   function automatic logic [CNT_W-1:0] step_toward(input logic [CNT_W-1:0] cur,
                                                    input logic [CNT_W-1:0] stp,
                                                    input logic [CNT_W-1:0] tgt,
                                                    input logic             up);
      logic [CNT_W:0]   sum;
      logic [CNT_W-1:0] res;
      sum = {1'b0, cur} + {1'b0, stp};
      if (up)
         res = (sum[CNT_W] || (sum[CNT_W-1:0] > tgt)) ? tgt : sum[CNT_W-1:0];
      else
         res = ((stp > cur) || ((cur - stp) < tgt)) ? tgt : (cur - stp);
      return floor_min(res);
   endfunction

   always_comb begin
      wrap       = (state == S_RUN) && (prev_addr == '1) && (gen_addr == '0);
      dwell_eff  = (dwell_cfg == '0) ? DWELL_W'(1) : dwell_cfg;
      dwell_next = {1'b0, dwell_cnt} + (DWELL_W+1)'(1);
      step_done  = wrap && (dwell_next >= {1'b0, dwell_eff});
      at_end     = (set_count == tgt_cnt) || (step_cnt == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         base_cnt  <= '0;
         tgt_cnt   <= '0;
         step_cnt  <= '0;
         dwell_cfg <= '0;
         dwell_cnt <= '0;
         mode      <= '0;
         sig_cfg   <= '0;
         dir_up    <= 1'b0;
         prev_addr <= '0;
         set_count <= '0;
         sig_type  <= '0;
         gen_rst_n <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state     <= S_IDLE;
            gen_rst_n <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  gen_rst_n <= 1'b0;
                  if (start) begin
                     base_cnt  <= cfg_start_cnt;
                     tgt_cnt   <= cfg_stop_cnt;
                     step_cnt  <= cfg_step;
                     dwell_cfg <= cfg_dwell;
                     mode      <= cfg_mode;
                     sig_cfg   <= cfg_sig_type;
                     busy      <= 1'b1;
                     state     <= S_LOAD;
                  end
               end
               S_LOAD: begin
                  // Direction comes from the raw values; endpoints are stored floored.
                  dir_up    <= (tgt_cnt >= base_cnt);
                  base_cnt  <= floor_min(base_cnt);
                  tgt_cnt   <= floor_min(tgt_cnt);
                  set_count <= floor_min(base_cnt);
                  sig_type  <= sig_cfg;
                  dwell_cnt <= '0;
                  prev_addr <= '0;
                  gen_rst_n <= 1'b1;
                  state     <= S_RUN;
               end
               S_RUN: begin
                  prev_addr <= gen_addr;
                  if (wrap && !step_done) begin
                     dwell_cnt <= dwell_next[DWELL_W-1:0];
                  end else if (step_done) begin
                     dwell_cnt <= '0;
                     if (!at_end) begin
                        set_count <= step_toward(set_count, step_cnt, tgt_cnt, dir_up);
                     end else if (mode == 2'd0 || mode == 2'd3) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        gen_rst_n <= 1'b0;
                        state     <= S_IDLE;
                     end else if (mode == 2'd1 || step_cnt == '0) begin
                        set_count <= base_cnt;
                     end else begin
                        // Ping-pong: endpoints swap and the first step back is taken now.
                        base_cnt  <= tgt_cnt;
                        tgt_cnt   <= base_cnt;
                        dir_up    <= !dir_up;
                        set_count <= step_toward(set_count, step_cnt, base_cnt, !dir_up);
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Bench for sweep_ctrl: drives the generator address directly and compares set_count against
// a step-value list computed from the sweep rules.
module tb_sweep_ctrl;
   localparam int CNT_W     = 32;
   localparam int ADDR_W    = 4;
   localparam int DWELL_W   = 16;
   localparam int MIN_COUNT = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic               abort;
   logic [CNT_W-1:0]   cfg_start_cnt;
   logic [CNT_W-1:0]   cfg_stop_cnt;
   logic [CNT_W-1:0]   cfg_step;
   logic [DWELL_W-1:0] cfg_dwell;
   logic [1:0]         cfg_mode;
   logic [3:0]         cfg_sig_type;
   logic [ADDR_W-1:0]  gen_addr;
   logic [CNT_W-1:0]   set_count;
   logic [3:0]         sig_type;
   logic               gen_rst_n;
   logic               busy;
   logic               done;

   int     checks   = 0;
   int     failures = 0;
   longint exp_q[$];
   bit     seq_ends;

   sweep_ctrl #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .DWELL_W(DWELL_W), .MIN_COUNT(MIN_COUNT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cfg_start_cnt(cfg_start_cnt), .cfg_stop_cnt(cfg_stop_cnt), .cfg_step(cfg_step),
      .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .cfg_sig_type(cfg_sig_type),
      .gen_addr(gen_addr), .set_count(set_count), .sig_type(sig_type),
      .gen_rst_n(gen_rst_n), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint flr(input longint v);
      return (v < MIN_COUNT) ? longint'(MIN_COUNT) : v;
   endfunction

   // Expected list of set_count values, one per step, straight from the sweep rules.
   function automatic void build_seq(input longint s, input longint e, input longint st,
                                     input int md, input int maxn);
      longint a, b, v, t;
      bit     up;
      exp_q.delete();
      seq_ends = 1'b0;
      a  = flr(s);
      b  = flr(e);
      up = (e >= s);
      v  = a;
      exp_q.push_back(v);
      while (exp_q.size() < maxn) begin
         if (v == b || st == 0) begin
            if (md == 0 || md == 3) begin
               seq_ends = 1'b1;
               break;
            end else if (md == 1 || st == 0) begin
               v = a;
            end else begin
               t  = a;
               a  = b;
               b  = t;
               up = !up;
               v  = up ? ((v + st > b) ? b : v + st) : ((v - st < b) ? b : v - st);
            end
         end else begin
            v = up ? ((v + st > b) ? b : v + st) : ((v - st < b) ? b : v - st);
         end
         exp_q.push_back(v);
      end
   endfunction

   task automatic scramble_cfg;
      cfg_start_cnt = $urandom;
      cfg_stop_cnt  = $urandom;
      cfg_step      = $urandom;
      cfg_dwell     = DWELL_W'($urandom);
      cfg_mode      = 2'($urandom);
      cfg_sig_type  = 4'($urandom);
   endtask

   // One generator period with random stalls; stray start pulses must be ignored.
   task automatic run_period(input longint cur);
      repeat ($urandom_range(0, 2)) begin
         tick;
         chk("hold_at_zero", set_count, cur);
      end
      for (int a = 1; a < 16; a++) begin
         gen_addr = ADDR_W'(a);
         start = ($urandom_range(0, 15) == 0);
         if (start) scramble_cfg();
         repeat (1 + $urandom_range(0, 1)) begin
            tick;
            start = 1'b0;
            chk("dwell_hold", set_count, cur);
            chk("busy_run", busy, 1);
            chk("no_done_mid", done, 0);
         end
      end
      gen_addr = '0;
      tick;
   endtask

   // ending: 0 = abort, 1 = reset, used when the sweep never completes on its own.
   task automatic do_sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                           input logic [15:0] dw, input logic [1:0] md, input logic [3:0] sg,
                           input int maxn, input int ending);
      int dwe, nrun;
      build_seq(longint'(s), longint'(e), longint'(st), int'(md), maxn);
      dwe  = (dw == 0) ? 1 : int'(dw);
      nrun = seq_ends ? exp_q.size() : exp_q.size() - 1;
      cfg_start_cnt = s;
      cfg_stop_cnt  = e;
      cfg_step      = st;
      cfg_dwell     = dw;
      cfg_mode      = md;
      cfg_sig_type  = sg;
      gen_addr      = '0;
      start         = 1'b1;
      tick;
      start = 1'b0;
      scramble_cfg();
      chk("load_busy", busy, 1);
      chk("load_gen_rst", gen_rst_n, 0);
      tick;
      chk("run_gen_rst", gen_rst_n, 1);
      chk("run_first_cnt", set_count, exp_q[0]);
      chk("run_sig_type", sig_type, sg);
      for (int i = 0; i < nrun; i++) begin
         for (int d = 0; d < dwe; d++) begin
            run_period(exp_q[i]);
            if (d < dwe - 1) begin
               chk("mid_dwell_cnt", set_count, exp_q[i]);
               chk("mid_dwell_done", done, 0);
            end else if (i < exp_q.size() - 1) begin
               chk("step_cnt", set_count, exp_q[i+1]);
               chk("step_done", done, 0);
               chk("step_busy", busy, 1);
            end else begin
               chk("end_done", done, 1);
               chk("end_busy", busy, 0);
               chk("end_gen_rst", gen_rst_n, 0);
               chk("end_cnt_held", set_count, exp_q[i]);
               tick;
               chk("done_one_cycle", done, 0);
               chk("idle_cnt_held", set_count, exp_q[i]);
            end
         end
      end
      if (!seq_ends) begin
         chk("sig_type_kept", sig_type, sg);
         if (ending == 0) begin
            abort = 1'b1;
            tick;
            abort = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_gen_rst", gen_rst_n, 0);
            chk("abort_no_done", done, 0);
            tick;
            chk("abort_stays_idle", busy, 0);
            chk("abort_no_done2", done, 0);
         end else begin
            rst_n = 1'b0;
            tick;
            chk("rst_set_count", set_count, 0);
            chk("rst_sig_type", sig_type, 0);
            chk("rst_gen_rst", gen_rst_n, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            rst_n = 1'b1;
            tick;
            chk("rst_idle", busy, 0);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      gen_addr = '0;
      scramble_cfg();

      // Reset held three cycles.
      repeat (3) tick;
      chk("reset_set_count", set_count, 0);
      chk("reset_gen_rst", gen_rst_n, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_sig_type", sig_type, 0);
      rst_n = 1'b1;
      tick;

      // Up sweep, down sweep with floor, wrap-around clamps.
      do_sweep(32'd4, 32'd10, 32'd3, 16'd2, 2'd0, 4'd5, 64, 0);
      do_sweep(32'd5, 32'd0, 32'd2, 16'd1, 2'd0, 4'd9, 64, 0);
      do_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 16'd1, 2'd3, 4'd1, 64, 0);
      do_sweep(32'h20, 32'd3, 32'h30, 16'd1, 2'd0, 4'd2, 64, 0);

      // Ping-pong until abort.
      do_sweep(32'd2, 32'd6, 32'd4, 16'd1, 2'd2, 4'd3, 6, 0);

      // start and abort together in IDLE: abort wins.
      start = 1'b1;
      abort = 1'b1;
      tick;
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_busy", busy, 0);
      chk("start_abort_gen_rst", gen_rst_n, 0);
      tick;
      chk("start_abort_idle", busy, 0);
      chk("start_abort_gen_rst2", gen_rst_n, 0);

      // Repeat mode with zero step and zero dwell, then reset mid-run.
      do_sweep(32'd7, 32'd100, 32'd0, 16'd0, 2'd1, 4'd12, 5, 1);

      // Randomized sweeps.
      for (int k = 0; k < 10; k++) begin
         do_sweep($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 6),
                  16'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom),
                  6, int'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
